pattern_writer: RTL and testbench
=================================

PATTERN_WRITER -- requirements
Module: pattern_writer

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, meaning maximum sequence length (levels), range 1..16.
REQ-002 SHALL have parameter SHOW_CYCLES, default 4, meaning clock cycles each symbol is shown, range 1..255.
REQ-003 SHALL have parameter SEED, default 8'hA5, meaning LFSR reset value; a value of 0 SHALL be replaced by 8'h01.
REQ-004 SHALL have port clk, input, 1 bit, meaning the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit, meaning synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit, meaning a level pulse that begins a new game.
REQ-007 SHALL have port result, input, 2 bits, meaning the comparator verdict: 00 none, 01 match, 10 mismatch, 11 reserved.
REQ-008 SHALL have port out_wr, output, 2 bits, meaning the current sequence symbol.
REQ-009 SHALL have port wr_valid, output, 1 bit, meaning out_wr is being shown to the player.
REQ-010 SHALL have port cmp_valid, output, 1 bit, meaning out_wr is the expected symbol for the current guess.
REQ-011 SHALL have port level, output, 5 bits, meaning the current sequence length, 0 when idle.
REQ-012 SHALL have ports game_over and win, output, 1 bit each, meaning the game has ended and the ending was a win.

Function
REQ-013 SHALL implement states IDLE, GEN, SHOW, GAP, WAIT, WIN and LOSE.
REQ-014 IDLE SHALL drive out_wr=0, wr_valid=0, cmp_valid=0 and level=0; start=1 SHALL go to GEN with level=1.
REQ-015 The LFSR SHALL be 8-bit Fibonacci: next={l[6:0], l[7]^l[5]^l[4]^l[3]}.
REQ-016 GEN SHALL last 1 cycle: advance the LFSR, write next[1:0] into mem[level-1], clear idx, then go to SHOW.
REQ-017 SHOW SHALL drive out_wr=mem[idx] and wr_valid=1 for exactly SHOW_CYCLES cycles, then go to GAP.
REQ-018 GAP SHALL last 1 cycle with out_wr=0 and wr_valid=0, then increment idx.
REQ-019 After GAP, the block SHALL go to WAIT with idx=0 if idx reaches level, otherwise back to SHOW.
REQ-020 WAIT SHALL drive out_wr=mem[idx] and cmp_valid=1; result 00 or 11 SHALL hold the state.
REQ-021 In WAIT, result=01 SHALL handle the guess as follows:
- if idx<level-1: increment idx;
- else if level==MAX_LEN: go to WIN;
- else: increment level and go to GEN.
REQ-022 In WAIT, result=10 SHALL go to LOSE.
REQ-023 The result input SHALL be sampled only in WAIT; result in any other state SHALL be ignored.
REQ-024 WIN and LOSE SHALL drive game_over=1 (win=1 in WIN only) and keep level frozen.
REQ-025 start=1 in WIN or LOSE SHALL go to GEN with level=1; the LFSR SHALL NOT be reloaded, so the new sequence differs.
REQ-026 start SHALL be ignored in GEN, SHOW, GAP and WAIT.
REQ-027 Earlier mem entries SHALL persist across levels; each level appends exactly one symbol.
REQ-028 Latency: with start sampled at cycle N, GEN SHALL be at N+1 and the first wr_valid=1 at N+2.

Reset
REQ-029 rst=1 SHALL force IDLE, load the LFSR with SEED, clear idx, level, mem and all outputs to 0, and take priority over start.
REQ-030 rst asserted mid-game, in any state, SHALL abort to IDLE on the next edge with no further wr_valid or cmp_valid.

Structure
REQ-031 Package pattern_pkg SHALL hold the result codes (RES_NONE, RES_MATCH, RES_MISS), the state encoding and the LFSR tap constant.
REQ-032 The LFSR SHALL be a separate sub-module lfsr8 with ports clk, rst, en, seed and q.
REQ-033 Sequence storage SHALL be a register array of MAX_LEN x 2 bits; no RAM inference is required.

Verification
REQ-034 Bench SHALL cover: defaults, start at N -> out_wr=2'b10 (LFSR 8'hA5->8'h4A) with wr_valid high N+2..N+5, GAP at N+6, cmp_valid=1 from N+7.
REQ-035 Bench SHALL cover: level 1, result=01 in WAIT -> GEN, level=2, the first symbol replayed unchanged, then the second symbol.
REQ-036 Bench SHALL cover: level 3, result=01, 01, 10 -> LOSE, game_over=1, win=0, level=3 held.
REQ-037 Bench SHALL cover: MAX_LEN=2 and all matches -> WIN, game_over=1, win=1; start then gives level=1 with a symbol taken from the continued LFSR.
REQ-038 Bench SHALL cover: rst pulsed during SHOW at level 2 -> next cycle IDLE with all outputs 0, and start then reproduces the REQ-034 sequence.
REQ-039 Bench SHALL cover: result=11 held in WAIT, and start pulsed in SHOW -> no state change, no level change.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared types for the pattern_writer memory game: comparator verdicts,
// controller states and the LFSR feedback rule.
package pattern_pkg;

    typedef enum logic [1:0] {
        RES_NONE  = 2'b00,
        RES_MATCH = 2'b01,
        RES_MISS  = 2'b10,
        RES_RSVD  = 2'b11
    } result_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GEN,
        ST_SHOW,
        ST_GAP,
        ST_WAIT,
        ST_WIN,
        ST_LOSE
    } state_e;

    // Feedback taps at bits 7, 5, 4 and 3.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR that advances one step per cycle while en is high.
module lfsr8
    import pattern_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    logic [7:0] lfsr_q;

    // NOTE: sequential state is written with <= so every register samples
    // the pre-edge values; blocking = here would chain updates within a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= seed;
        end else if (en) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/pattern_writer.sv
// Memory-game sequencer: grows a random 2-bit symbol sequence one level at a
// time, shows it to the player, then walks it against comparator verdicts.
module pattern_writer
    import pattern_pkg::*;
#(
    parameter int unsigned MAX_LEN     = 8,
    parameter int unsigned SHOW_CYCLES = 4,
    parameter logic [7:0]  SEED        = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] result,
    output logic [1:0] out_wr,
    output logic       wr_valid,
    output logic       cmp_valid,
    output logic [4:0] level,
    output logic       game_over,
    output logic       win
);

    // An all-zero seed would lock the LFSR at zero forever.
    localparam logic [7:0] SEED_EFF  = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [7:0] SHOW_LAST = 8'(SHOW_CYCLES - 1);
    localparam logic [4:0] LEN_MAX   = 5'(MAX_LEN);

    state_e     state_q;
    logic [4:0] idx_q;
    logic [4:0] level_q;
    logic [7:0] cnt_q;
    logic [1:0] mem_q [MAX_LEN];
    logic [1:0] out_wr_q;
    logic       wr_valid_q;
    logic       cmp_valid_q;
    logic       game_over_q;
    logic       win_q;

    logic [7:0] lfsr_q;
    logic [1:0] sym_d;

    lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == ST_GEN),
        .seed (SEED_EFF),
        .q    (lfsr_q)
    );

    // The symbol appended in GEN is taken from the value the LFSR steps to.
    assign sym_d = 2'(lfsr_next(lfsr_q));

    function automatic logic [1:0] mem_at(input logic [4:0] i);
        logic [1:0] r;
        r = 2'b00;
        for (int k = 0; k < MAX_LEN; k++) begin
            if (i == 5'(k)) r = mem_q[k];
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            level_q     <= '0;
            cnt_q       <= '0;
            out_wr_q    <= '0;
            wr_valid_q  <= 1'b0;
            cmp_valid_q <= 1'b0;
            game_over_q <= 1'b0;
            win_q       <= 1'b0;
            // NOTE: the symbol array is a small flop bank, so clearing it in
            // reset is cheap and keeps every read defined; a RAM would not be.
            for (int i = 0; i < MAX_LEN; i++) begin
                mem_q[i] <= 2'b00;
            end
        end else begin
            case (state_q)
                ST_IDLE, ST_WIN, ST_LOSE: begin
                    if (start) begin
                        state_q     <= ST_GEN;
                        level_q     <= 5'd1;
                        idx_q       <= '0;
                        out_wr_q    <= '0;
                        game_over_q <= 1'b0;
                        win_q       <= 1'b0;
                    end
                end
                ST_GEN: begin
                    for (int i = 0; i < MAX_LEN; i++) begin
                        if (level_q == 5'(i + 1)) mem_q[i] <= sym_d;
                    end
                    idx_q      <= '0;
                    cnt_q      <= '0;
                    state_q    <= ST_SHOW;
                    wr_valid_q <= 1'b1;
                    // At level 1 the entry being written is the one shown first.
                    out_wr_q   <= (level_q == 5'd1) ? sym_d : mem_at(5'd0);
                end
                ST_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_q    <= ST_GAP;
                        wr_valid_q <= 1'b0;
                        out_wr_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_GAP: begin
                    if (idx_q + 5'd1 == level_q) begin
                        state_q     <= ST_WAIT;
                        idx_q       <= '0;
                        cmp_valid_q <= 1'b1;
                        out_wr_q    <= mem_at(5'd0);
                    end else begin
                        state_q    <= ST_SHOW;
                        idx_q      <= idx_q + 5'd1;
                        cnt_q      <= '0;
                        wr_valid_q <= 1'b1;
                        out_wr_q   <= mem_at(idx_q + 5'd1);
                    end
                end
                ST_WAIT: begin
                    case (result_e'(result))
                        RES_MATCH: begin
                            if (idx_q + 5'd1 < level_q) begin
                                idx_q    <= idx_q + 5'd1;
                                out_wr_q <= mem_at(idx_q + 5'd1);
                            end else begin
                                cmp_valid_q <= 1'b0;
                                out_wr_q    <= '0;
                                if (level_q == LEN_MAX) begin
                                    state_q     <= ST_WIN;
                                    game_over_q <= 1'b1;
                                    win_q       <= 1'b1;
                                end else begin
                                    state_q <= ST_GEN;
                                    level_q <= level_q + 5'd1;
                                end
                            end
                        end
                        RES_MISS: begin
                            state_q     <= ST_LOSE;
                            cmp_valid_q <= 1'b0;
                            out_wr_q    <= '0;
                            game_over_q <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_wr    = out_wr_q;
    assign wr_valid  = wr_valid_q;
    assign cmp_valid = cmp_valid_q;
    assign level     = level_q;
    assign game_over = game_over_q;
    assign win       = win_q;

endmodule

// File: tb/tb_pattern_writer.sv
// Self-checking bench: a game-level model predicts the output stream of two
// pattern_writer instances, compared every cycle, plus literal spot checks.
module tb_pattern_writer;

    typedef struct packed {
        logic [1:0] wr;
        logic       wv;
        logic       cv;
        logic [4:0] lvl;
        logic       go;
        logic       w;
    } obs_t;

    logic       clk;
    logic       rst_s     [2];
    logic       start_s   [2];
    logic [1:0] result_s  [2];
    logic [1:0] out_wr_s  [2];
    logic       wr_valid_s[2];
    logic       cmp_valid_s[2];
    logic [4:0] level_s   [2];
    logic       game_over_s[2];
    logic       win_s     [2];

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    // Expected-output stream per instance, plus the value it settles at.
    obs_t ring [2][256];
    int   head [2];
    int   tail [2];
    obs_t hold [2];

    // Game-level model state.
    logic [7:0] m_lfsr [2];
    logic [7:0] m_seed [2];
    logic [1:0] m_seq  [2][16];
    int         m_lvl  [2];
    int         m_idx  [2];
    int         m_max  [2];
    int         m_show [2];

    pattern_writer u0 (
        .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .result(result_s[0]),
        .out_wr(out_wr_s[0]), .wr_valid(wr_valid_s[0]), .cmp_valid(cmp_valid_s[0]),
        .level(level_s[0]), .game_over(game_over_s[0]), .win(win_s[0])
    );

    pattern_writer #(.MAX_LEN(2), .SHOW_CYCLES(1), .SEED(8'h00)) u1 (
        .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .result(result_s[1]),
        .out_wr(out_wr_s[1]), .wr_valid(wr_valid_s[1]), .cmp_valid(cmp_valid_s[1]),
        .level(level_s[1]), .game_over(game_over_s[1]), .win(win_s[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] step_lfsr(input logic [7:0] l);
        int v;
        int fb;
        v  = int'(l);
        fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
        return 8'(((v << 1) | fb) & 255);
    endfunction

    function automatic obs_t mk(input logic [1:0] wr, input logic wv, input logic cv,
                                input int lvl, input logic go, input logic w);
        obs_t o;
        o.wr  = wr;
        o.wv  = wv;
        o.cv  = cv;
        o.lvl = 5'(lvl);
        o.go  = go;
        o.w   = w;
        return o;
    endfunction

    task automatic push(input int k, input obs_t o);
        ring[k][tail[k] % 256] = o;
        tail[k]++;
    endtask

    // One round: a GEN cycle, every symbol shown then blanked, then guessing.
    task automatic plan_round(input int k);
        push(k, mk(2'b00, 1'b0, 1'b0, m_lvl[k], 1'b0, 1'b0));
        for (int i = 0; i < m_lvl[k]; i++) begin
            for (int c = 0; c < m_show[k]; c++)
                push(k, mk(m_seq[k][i], 1'b1, 1'b0, m_lvl[k], 1'b0, 1'b0));
            push(k, mk(2'b00, 1'b0, 1'b0, m_lvl[k], 1'b0, 1'b0));
        end
        hold[k]  = mk(m_seq[k][0], 1'b0, 1'b1, m_lvl[k], 1'b0, 1'b0);
        m_idx[k] = 0;
    endtask

    task automatic append_symbol(input int k);
        m_lfsr[k] = step_lfsr(m_lfsr[k]);
        m_seq[k][m_lvl[k] - 1] = m_lfsr[k][1:0];
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                obs_t e;
                if (head[k] != tail[k]) begin
                    e = ring[k][head[k] % 256];
                    head[k]++;
                end else begin
                    e = hold[k];
                end
                check($sformatf("u%0d.out_wr", k),    out_wr_s[k],    e.wr);
                check($sformatf("u%0d.wr_valid", k),  wr_valid_s[k],  e.wv);
                check($sformatf("u%0d.cmp_valid", k), cmp_valid_s[k], e.cv);
                check($sformatf("u%0d.level", k),     level_s[k],     e.lvl);
                check($sformatf("u%0d.game_over", k), game_over_s[k], e.go);
                check($sformatf("u%0d.win", k),       win_s[k],       e.w);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Drain predicted transients, then one more cycle so the DUT sits in the
    // settled state when the next action is sampled.
    task automatic wait_steady(input int k);
        int n;
        n = 0;
        while (head[k] != tail[k] && n < 300) begin
            tick();
            n++;
        end
        if (head[k] != tail[k]) begin
            n_cmp++;
            n_fail++;
            $display("FAIL u%0d.steady_timeout: %0d entries pending, required 0",
                     k, tail[k] - head[k]);
            head[k] = tail[k];
        end
        tick();
    endtask

    task automatic game_start(input int k);
        wait_steady(k);
        start_s[k] = 1'b1;
        m_lvl[k]   = 1;
        append_symbol(k);
        plan_round(k);
        tick();
        start_s[k] = 1'b0;
    endtask

    task automatic guess(input int k, input logic [1:0] r);
        wait_steady(k);
        result_s[k] = r;
        if (r == 2'b01) begin
            if (m_idx[k] < m_lvl[k] - 1) begin
                m_idx[k]++;
                hold[k] = mk(m_seq[k][m_idx[k]], 1'b0, 1'b1, m_lvl[k], 1'b0, 1'b0);
            end else if (m_lvl[k] == m_max[k]) begin
                hold[k] = mk(2'b00, 1'b0, 1'b0, m_lvl[k], 1'b1, 1'b1);
            end else begin
                m_lvl[k]++;
                append_symbol(k);
                plan_round(k);
            end
        end else if (r == 2'b10) begin
            hold[k] = mk(2'b00, 1'b0, 1'b0, m_lvl[k], 1'b1, 1'b0);
        end
        tick();
        result_s[k] = 2'b00;
    endtask

    task automatic apply_reset(input int k);
        rst_s[k]  = 1'b1;
        head[k]   = tail[k];
        hold[k]   = mk(2'b00, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        m_lfsr[k] = m_seed[k];
        m_lvl[k]  = 0;
        tick();
        rst_s[k]  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_seed[0] = 8'hA5; m_max[0] = 8; m_show[0] = 4;
        m_seed[1] = 8'h01; m_max[1] = 2; m_show[1] = 1;
        for (int k = 0; k < 2; k++) begin
            head[k] = 0; tail[k] = 0;
            m_lfsr[k] = m_seed[k]; m_lvl[k] = 0; m_idx[k] = 0;
            for (int i = 0; i < 16; i++) m_seq[k][i] = 2'b00;
            hold[k]     = mk(2'b00, 1'b0, 1'b0, 0, 1'b0, 1'b0);
            rst_s[k]    = 1'b1;
            start_s[k]  = 1'b1;
            result_s[k] = 2'b01;
        end
        tick();
        cmp_en = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            rst_s[k] = 1'b0; start_s[k] = 1'b0; result_s[k] = 2'b00;
        end
        check("rst.level", level_s[0], 0);
        check("rst.wr_valid", wr_valid_s[0], 0);
        check("rst.cmp_valid", cmp_valid_s[0], 0);
        check("rst.game_over", game_over_s[0], 0);

        // First game with defaults: A5 -> 4A gives symbol 2'b10.
        game_start(0);
        check("gen.level", level_s[0], 1);
        check("gen.wr_valid", wr_valid_s[0], 0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("show.wr_valid", wr_valid_s[0], 1);
            check("show.out_wr", out_wr_s[0], 2);
        end
        tick();
        check("gap.wr_valid", wr_valid_s[0], 0);
        tick();
        check("wait.cmp_valid", cmp_valid_s[0], 1);
        check("wait.out_wr", out_wr_s[0], 2);

        // Reserved verdict holds WAIT.
        result_s[0] = 2'b11;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rsvd.cmp_valid", cmp_valid_s[0], 1);
            check("rsvd.level", level_s[0], 1);
        end
        result_s[0] = 2'b00;

        // Level 2 replays 2'b10, then appends 2'b01 (4A -> 95).
        guess(0, 2'b01);
        check("l2.level", level_s[0], 2);
        tick();
        check("l2.sym0", out_wr_s[0], 2);
        repeat (3) tick();
        tick();
        tick();
        check("l2.sym1", out_wr_s[0], 1);
        start_s[0] = 1'b1;
        result_s[0] = 2'b10;
        tick();
        start_s[0] = 1'b0;
        result_s[0] = 2'b00;
        check("ignored.wr_valid", wr_valid_s[0], 1);
        check("ignored.level", level_s[0], 2);

        guess(0, 2'b01);
        guess(0, 2'b01);
        guess(0, 2'b01);
        guess(0, 2'b01);
        guess(0, 2'b10);
        check("lose.game_over", game_over_s[0], 1);
        check("lose.win", win_s[0], 0);
        check("lose.level", level_s[0], 3);
        repeat (3) tick();
        check("lose.level_held", level_s[0], 3);

        // Restart, reach level 2, reset in the middle of SHOW.
        game_start(0);
        guess(0, 2'b01);
        tick();
        tick();
        apply_reset(0);
        check("abort.level", level_s[0], 0);
        check("abort.wr_valid", wr_valid_s[0], 0);
        check("abort.out_wr", out_wr_s[0], 0);
        game_start(0);
        tick();
        check("replay.out_wr", out_wr_s[0], 2);
        wait_steady(0);

        // MAX_LEN=2, zero seed -> 01: symbols 10, 00, win, then 00 from 08.
        game_start(1);
        tick();
        check("u1.sym0", out_wr_s[1], 2);
        guess(1, 2'b01);
        guess(1, 2'b01);
        guess(1, 2'b01);
        check("win.game_over", game_over_s[1], 1);
        check("win.win", win_s[1], 1);
        check("win.level", level_s[1], 2);
        game_start(1);
        check("rewin.level", level_s[1], 1);
        tick();
        check("rewin.wr_valid", wr_valid_s[1], 1);
        check("rewin.out_wr", out_wr_s[1], 0);
        guess(1, 2'b01);
        wait_steady(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
